// File: rtl/fetch_queue.sv
// Instruction fetch: sequential PC generation, in-order memory requests and a DEPTH-entry
// instruction FIFO toward decode. Defining FETCH_PREDECODE_EN adds the inst_imm_type predecode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
`ifdef FETCH_PREDECODE_EN
  output logic [31:0] inst_pc,
  output logic [2:0]  inst_imm_type
`else
  output logic [31:0] inst_pc
`endif
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          PW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   pc_r;
  logic [31:0]   fill_pc_r;
  logic [31:0]   inst_r;
  logic [31:0]   inst_pc_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;

  logic [CW:0]   credit_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  logic [PW-1:0] rd_next_s;
  logic [CW-1:0] count_next_s;
  logic [31:0]   head_data_s;
  logic [31:0]   head_pc_s;

  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

`ifdef FETCH_PREDECODE_EN
  logic [2:0]    type_mem [DEPTH];
  logic [2:0]    head_type_s;
  logic [2:0]    imm_type_r;

  function automatic logic [2:0] imm_type_f(input logic [6:0] opcode);
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: imm_type_f = 3'b000;
      7'b0100011:                                     imm_type_f = 3'b001;
      7'b1100011:                                     imm_type_f = 3'b010;
      7'b1101111:                                     imm_type_f = 3'b011;
      7'b0110111, 7'b0010111:                         imm_type_f = 3'b100;
      default:                                        imm_type_f = 3'b111;
    endcase
  endfunction

  assign inst_imm_type = imm_type_r;
`endif

  assign req_addr   = pc_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign inst_valid = (count_r != {CW{1'b0}});

  // Handshake decisions and the head entry as it will look after this edge
  always_comb begin
    credit_s  = {1'b0, count_r} + {1'b0, outstanding_r};
    req_valid = rst_n & ~redirect_valid & (credit_s < DEPTH_W);
    issue_s   = req_valid & req_ready;
    push_s    = ~redirect_valid & rsp_valid & (drop_cnt_r == {CW{1'b0}});
    pop_s     = ~redirect_valid & inst_valid & inst_ready;
    if (pop_s) begin
      rd_next_s = rd_ptr_r + PW'(1'b1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
    if (redirect_valid) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r + CW'(push_s) - CW'(pop_s);
    end
    // A word pushed into an otherwise-empty queue becomes the head directly
    if (push_s && (rd_next_s == wr_ptr_r)) begin
      head_data_s = rsp_data;
      head_pc_s   = fill_pc_r;
    end else begin
      head_data_s = data_mem[rd_next_s];
      head_pc_s   = pc_mem[rd_next_s];
    end
`ifdef FETCH_PREDECODE_EN
    if (push_s && (rd_next_s == wr_ptr_r)) begin
      head_type_s = imm_type_f(rsp_data[6:0]);
    end else begin
      head_type_s = type_mem[rd_next_s];
    end
`endif
  end

  // FIFO storage, written on every accepted response
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem[wr_ptr_r] <= rsp_data;
      pc_mem[wr_ptr_r]   <= fill_pc_r;
`ifdef FETCH_PREDECODE_EN
      type_mem[wr_ptr_r] <= imm_type_f(rsp_data[6:0]);
`endif
    end
  end

  // PC, credit counters, FIFO pointers and the registered head outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      fill_pc_r     <= RESET_PC;
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      inst_r        <= 32'h0000_0000;
      inst_pc_r     <= 32'h0000_0000;
`ifdef FETCH_PREDECODE_EN
      imm_type_r    <= 3'b111;
`endif
    end else if (redirect_valid) begin
      // Everything still in flight, except a response landing now, is stale
      pc_r          <= redirect_pc & 32'hFFFF_FFFC;
      fill_pc_r     <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= outstanding_r - CW'(rsp_valid);
      drop_cnt_r    <= outstanding_r - CW'(rsp_valid);
    end else begin
      if (issue_s) begin
        pc_r <= pc_r + 32'd4;
      end
      outstanding_r <= outstanding_r + CW'(issue_s) - CW'(rsp_valid);
      if (rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
        drop_cnt_r <= drop_cnt_r - CW'(1'b1);
      end
      if (push_s) begin
        wr_ptr_r  <= wr_ptr_r + PW'(1'b1);
        fill_pc_r <= fill_pc_r + 32'd4;
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      if (count_next_s != {CW{1'b0}}) begin
        inst_r    <= head_data_s;
        inst_pc_r <= head_pc_s;
`ifdef FETCH_PREDECODE_EN
        imm_type_r <= head_type_s;
`endif
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of decode and the immediate extractor.
- Generates sequential PCs and issues in-order requests to instruction memory.
- Buffers returned 32-bit instruction words with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing buffered words and discarding in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered instructions; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  out  1  instruction memory request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  32  fetch address, word aligned.
- rsp_valid  in  1  in-order response valid; never back-pressured.
- rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  redirect (branch, jump or trap) this cycle.
- redirect_pc  in  32  new fetch PC.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts.
- inst  out  32  instruction word, feeds decode and the immediate extractor.
- inst_pc  out  32  PC of inst.
- inst_imm_type  out  3  present only with FETCH_PREDECODE_EN.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - inst_valid=0, req_valid=0, req_addr=RESET_PC, inst=0, inst_pc=0.
- Counters outstanding and drop_cnt are $clog2(DEPTH+1) bits wide.
- Issue:
  - req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - req_addr = pc.
  - On req_valid && req_ready: pc <= pc+4 (wraps mod 2^32) and outstanding++.
- Response:
  - Every rsp_valid decrements outstanding.
  - If drop_cnt>0: the word is discarded and drop_cnt--.
  - Otherwise {rsp_data, pc of that request} is pushed.
  - Entry PC comes from a DEPTH-entry shadow PC queue, or equivalently a fill-PC register advanced on each push.
  - The credit rule guarantees a push never finds the FIFO full.
- Output:
  - inst_valid = FIFO non-empty.
  - inst and inst_pc come from the head entry.
  - Pop on inst_valid && inst_ready.
  - No bypass: a word pushed in cycle N is visible at earliest in cycle N+1.
- Simultaneous push and pop with the FIFO full or empty are both legal; count is unchanged by a simultaneous push and pop.
- Redirect (single-cycle pulse, highest priority):
  - FIFO is flushed; count=0.
  - pc <= {redirect_pc[31:2], 2'b00}; low bits are silently dropped.
  - drop_cnt <= outstanding - rsp_valid: every older request still in flight is discarded.
  - req_valid is low in the redirect cycle.
  - Any pop handshake in that cycle is void (decode is flushed too).
  - Any response arriving in that cycle is discarded.
- Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Mid-operation reset clears everything immediately; responses to pre-reset requests must not arrive after reset (system guarantee).
- inst and inst_pc hold their last values while inst_valid=0.

Optional Feature:
- Macro: FETCH_PREDECODE_EN.
- When defined, the FIFO stores 3 extra bits per entry, computed from rsp_data[6:0] at push time, and exposes them on inst_imm_type so decode drives the immediate extractor without an opcode decode on its critical path.
- Opcode map:
  - 0000011/0010011/1100111/1110011 -> 3'b000 (I)
  - 0100011 -> 3'b001 (S)
  - 1100011 -> 3'b010 (B)
  - 1101111 -> 3'b011 (J)
  - 0110111/0010111 -> 3'b100 (U)
  - anything else -> 3'b111
- inst_imm_type resets to 3'b111.
- When not defined, the port and storage are absent; the behaviour is otherwise identical.

Test Plan:
- Streaming:
  - Stimulus: reset, req_ready=1, 1-cycle memory returning word = address, inst_ready=1.
  - Response: req_addr 0,4,8,...; inst_pc/inst pairs 0/0, 4/4, 8/8 with no gaps after initial fill.
- Backpressure:
  - Stimulus: inst_ready=0 for 20 cycles, DEPTH=4.
  - Response: exactly 4 requests issued; inst_valid=1 with inst_pc=0 held; on release, pcs 0,4,8,12,16 delivered in order.
- Redirect with two in flight:
  - Stimulus: 2-cycle memory latency, redirect_pc=32'h100 while outstanding=2.
  - Response: both stale responses dropped; next inst_pc=32'h100; no stale word reaches decode.
- Redirect coinciding with rsp_valid and pop:
  - Response: that word is discarded, drop_cnt=outstanding-1; next delivered inst_pc equals the redirect target.
- Misaligned redirect:
  - Stimulus: redirect_pc=32'h203.
  - Response: req_addr=32'h200; wrap check from pc 32'hFFFF_FFFC gives next req_addr 0.
- Predecode, with FETCH_PREDECODE_EN:
  - Stimulus: words 32'h00500093 (addi), 32'h00112023 (sw), 32'h0000006F (jal), 32'h00000033 (add).
  - Response: inst_imm_type 000, 001, 011, 111.
